regfile_scoreboard: RTL

- 8 x 16-bit general-purpose register file sitting directly upstream of the ALU.
- Two combinational read ports drive ALU operands a and b. A single write-back port accepts the ALU result and its zero output.
- Per-register busy bits provide hazard detection for the issue logic.
- A registered zero flag captures the ALU zero output of the last write-back, for use by branch logic.

---
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with 8 x 16-bit registers that feeds the ALU operands. It
// also holds per-register busy bits that the issue logic uses for hazard
// detection.
//   - Register 0 always reads as zero. Writes to it are discarded, and its
//     busy bit is never set.
//   - Two combinational read ports. A write-back to the same address in the
//     same cycle is forwarded straight to the port (write-through bypass).
//   - One write-back port. It writes wb_data into the array and captures
//     wb_zero into zero_flag for the branch logic.
//   - Busy bits are set on issue and cleared on write-back. When both name
//     the same register in one cycle, the set wins.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   rd_addr1/rd_addr2      read addresses
//   rd_data1/rd_data2      read data (ALU a / ALU b)
//   busy1/busy2            operand at rd_addrN has an outstanding write
//   issue_en/issue_rd      an instruction writing issue_rd issues this cycle
//   wb_en/wb_addr/wb_data  write-back strobe, destination and ALU result
//   wb_zero                ALU zero output accompanying wb_data
//   zero_flag              zero output of the last write-back (registered)
//   busy_vec               all busy bits, bit i = register i
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                busy1,
    output logic                busy2,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                wb_zero,
    output logic                zero_flag,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic bypass1, bypass2;
    logic reissue1, reissue2;

    // Busy-bit update. The issue is applied after the write-back so that a
    // same-cycle set overrides the clear: the newer writer is still pending.
    // NOTE: assigning the default first in always_comb guarantees every path
    // drives busy_next, so no latch can be inferred.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the register array is reset along with the control state. This
    // makes the reads defined from reset onward instead of returning X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            zero_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register in this block
            // sample the pre-edge values, independent of statement order.
            if (wb_en && (wb_addr != '0)) begin
                regs[wb_addr] <= wb_data;
            end
            // Compare-only ops target r0 but still update the flag.
            if (wb_en) begin
                zero_flag <= wb_zero;
            end
            busy <= busy_next;
        end
    end

    // Bypass is active when this cycle's write-back targets the operand.
    assign bypass1  = wb_en && (wb_addr == rd_addr1) && (rd_addr1 != '0);
    assign bypass2  = wb_en && (wb_addr == rd_addr2) && (rd_addr2 != '0);
    assign reissue1 = issue_en && (issue_rd == rd_addr1);
    assign reissue2 = issue_en && (issue_rd == rd_addr2);

    assign rd_data1 = (rd_addr1 == '0) ? '0 : (bypass1 ? wb_data : regs[rd_addr1]);
    assign rd_data2 = (rd_addr2 == '0) ? '0 : (bypass2 ? wb_data : regs[rd_addr2]);

    // The forwarded result un-busies the operand. The exception is a
    // same-cycle issue that re-targets the register: that keeps it busy.
    assign busy1 = (rd_addr1 != '0) && busy[rd_addr1] && !(bypass1 && !reissue1);
    assign busy2 = (rd_addr2 != '0) && busy[rd_addr2] && !(bypass2 && !reissue2);

    assign busy_vec = busy;

endmodule
